// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl: bit-serial WIDTH-bit subtractor, diff = a - b - bin (mod 2^WIDTH).
// Latency: out_valid rises WIDTH cycles after the operand accept edge; one op at a time.
// Backpressure: holds the result in DONE while out_ready is low; in_ready only in IDLE.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake carrying a, b, bin
//   out_valid/out_ready   result handshake carrying diff, borrow_out, zero
//   busy                  high while an operation is in flight (RUN or DONE)

// Single-bit full subtractor: d = x - y - bin, bout = borrow into the next bit.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

module serial_subtract_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   result;
  logic [CNT_W-1:0]   cnt;
  logic               brw;
  logic               fs_d;
  logic               fs_bout;
  logic               accept;
  logic               last_bit;

  full_subtractor u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (brw),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign accept   = (state == IDLE) && in_valid;
  // The edge that consumes bit WIDTH-1 is also the edge that enters DONE.
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = in_valid ? RUN : IDLE;
      RUN:     state_nxt = last_bit ? DONE : RUN;
      DONE:    state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operands shift out LSB-first, difference bits enter result at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      brw    <= 1'b0;
      result <= '0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      brw    <= bin;
      result <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      brw    <= fs_bout;
      result <= {fs_d, result[WIDTH-1:1]};
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Outputs decode from state and registers only. Result fields are gated to DONE
  // so they read as zero outside a valid result (including straight after reset).
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    diff       = '0;
    borrow_out = 1'b0;
    zero       = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        diff       = result;
        borrow_out = brw;
        zero       = (result == '0);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// tb_serial_subtract_ctrl: self-checking bench for serial_subtract_ctrl.
// Table vectors, hand-written reset/backpressure sequences, and random ops vs. an arithmetic model.
module tb_serial_subtract_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zero;
  logic         busy;

  int errors = 0;
  int checks = 0;

  serial_subtract_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zero       (zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer subtraction; borrow is the sign of the exact result.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       output logic [W-1:0] d, output logic bo, output logic z);
    int v;
    v  = int'(x) - int'(y) - int'(c);
    bo = (v < 0);
    d  = v[W-1:0];
    z  = (d == 0);
  endtask

  // Runs one operation. Entered and left just after a falling edge.
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini,
                       input int pre, input int stall, input bit poke,
                       output logic [W-1:0] d, output logic bo, output logic z);
    int lat;
    int n;
    repeat (pre) @(negedge clk);
    a = ai; b = bi; bin = bini; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (lat = 0; lat < 40; lat++) begin
      @(negedge clk);
      if (out_valid) break;
      if (poke) begin
        check("in_ready_run", 32'(in_ready), 32'd0);
        in_valid = lat[0];
        a = 8'h01; b = 8'h01; bin = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'(W));
    d = diff; bo = borrow_out; z = zero;
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      in_valid  = poke;
      if (poke) begin a = 8'h01; b = 8'h01; end
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_diff", 32'(diff), 32'(d));
      check("hold_borrow", 32'(borrow_out), 32'(bo));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         z;
  } vec_t;

  vec_t vecs[8];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   32'(in_ready),   32'd1);
    check({tag, "_out_valid"},  32'(out_valid),  32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_diff"},       32'(diff),       32'd0);
    check({tag, "_borrow_out"}, 32'(borrow_out), 32'd0);
    check({tag, "_zero"},       32'(zero),       32'd0);
  endtask

  initial begin
    logic [W-1:0] d, ed, ra, rb;
    logic         bo, z, ebo, ez, rc;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7A, 8'h7A, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors; entry 4 exercises backpressure and ignored in_valid pulses.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, (i == 4) ? 5 : 0, (i == 4), d, bo, z);
      check($sformatf("vec%0d_diff", i),   32'(d),  32'(vecs[i].d));
      check($sformatf("vec%0d_borrow", i), 32'(bo), 32'(vecs[i].bo));
      check($sformatf("vec%0d_zero", i),   32'(z),  32'(vecs[i].z));
    end

    // Asynchronous reset in the middle of 0x80 - 0x01.
    a = 8'h80; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrun_busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    check_reset_outputs("midrun_held");
    rst_n = 1'b1;
    @(negedge clk);
    do_op(8'h80, 8'h01, 1'b0, 0, 0, 1'b0, d, bo, z);
    check("after_reset_diff",   32'(d),  32'h7F);
    check("after_reset_borrow", 32'(bo), 32'd0);

    // Random operations with input/output stalls against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if (i % 10 == 0) rb = ra;
      do_op(ra, rb, rc, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), d, bo, z);
      model(ra, rb, rc, ed, ebo, ez);
      check("rand_diff",   32'(d),  32'(ed));
      check("rand_borrow", 32'(bo), 32'(ebo));
      check("rand_zero",   32'(z),  32'(ez));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
